// File: rtl/dram_fifo_sync.sv
// rtl/dram_fifo_sync.sv - FWFT synchronous FIFO on distributed RAM with count, thresholds and sticky errors
module dram_fifo_sync #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int AF_LVL = 2**AW - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LVL_C = AF_LVL[AW:0];
  localparam logic [AW:0] AE_LVL_C = AE_LVL[AW:0];

  // Storage is never reset so it can map onto LUT RAM.
  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        wr_acc, rd_acc;

  // Pointer-derived status; the wrap bit separates full from empty.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    almost_full  = (count_q >= AF_LVL_C);
    almost_empty = (count_q <= AE_LVL_C);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    rd_data      = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state: accept rules against current flags, clr overrides everything.
  always_comb begin
    wr_acc      = wr_en & ~full;
    rd_acc      = rd_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc) count_d = count_q + PTR_ONE;
    if (rd_acc && !wr_acc) count_d = count_q - PTR_ONE;
    if (clr) begin
      wr_acc      = 1'b0;
      rd_acc      = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Synchronous write port of the RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_dram_fifo_sync.sv
// tb/tb_dram_fifo_sync.sv - directed self-checking bench for dram_fifo_sync
module tb_dram_fifo_sync;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int n_total = 0;
  int n_pass  = 0;

  dram_fifo_sync #(.DW(8), .AW(4), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1; wr_en = 1'b0;
    step();
    rd_en = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_data = 8'h00; idle();
    #3;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_aempty", {31'd0, almost_empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_afull", {31'd0, almost_full}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_unf", {31'd0, underflow}, 32'd0);
    #9 rst_n = 1'b1;

    // 1: three words, fall-through and ordered pops
    push(8'h11);
    check("t1_ft_data", {24'd0, rd_data}, 32'h11);
    check("t1_ft_empty", {31'd0, empty}, 32'd0);
    push(8'h22);
    push(8'h33);
    check("t1_count3", {27'd0, count}, 32'd3);
    pop_check("t1_pop0", 8'h11);
    pop_check("t1_pop1", 8'h22);
    pop_check("t1_pop2", 8'h33);
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_count0", {27'd0, count}, 32'd0);

    // 2: fill to full, thresholds, overflow, drain
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      check("t2_afull", {31'd0, almost_full}, (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("t2_full", {31'd0, full}, (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    push(8'hEE);
    check("t2_ovf", {31'd0, overflow}, 32'd1);
    check("t2_count16", {27'd0, count}, 32'd16);
    for (int i = 0; i < 16; i++) pop_check("t2_drain", 8'(i));
    check("t2_empty", {31'd0, empty}, 32'd1);

    // 3: underflow, then write+read while empty
    flush();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("t3_unf", {31'd0, underflow}, 32'd1);
    check("t3_count0", {27'd0, count}, 32'd0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5; step(); idle();
    check("t3_count1", {27'd0, count}, 32'd1);
    check("t3_unf_hold", {31'd0, underflow}, 32'd1);
    pop_check("t3_data", 8'hA5);

    // 4: steady-state streaming at count 5 across pointer wraps
    flush();
    for (int i = 0; i < 5; i++) push(8'(i));
    for (int i = 0; i < 40; i++) begin
      check("t4_head", {24'd0, rd_data}, 32'(i));
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(i + 5);
      step();
      check("t4_count5", {27'd0, count}, 32'd5);
    end
    idle();
    for (int i = 40; i < 45; i++) pop_check("t4_tail", 8'(i));
    check("t4_empty", {31'd0, empty}, 32'd1);

    // 5: write+read while full drops the write
    flush();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF; step(); idle();
    check("t5_count15", {27'd0, count}, 32'd15);
    check("t5_ovf", {31'd0, overflow}, 32'd1);
    check("t5_full0", {31'd0, full}, 32'd0);
    for (int i = 1; i < 16; i++) pop_check("t5_drain", 8'(8'h80 + i));
    check("t5_empty", {31'd0, empty}, 32'd1);

    // 6: clr with a write pending, then async reset mid-burst
    flush();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'h55);
    for (int i = 0; i < 7; i++) pop_check("t6_pre", 8'(i));
    check("t6_count9", {27'd0, count}, 32'd9);
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99; step(); idle();
    check("t6_clr_count", {27'd0, count}, 32'd0);
    check("t6_clr_empty", {31'd0, empty}, 32'd1);
    check("t6_clr_ovf", {31'd0, overflow}, 32'd0);
    check("t6_clr_unf", {31'd0, underflow}, 32'd0);
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data = 8'(8'h60 + i); step(); end
    check("t6_burst_count", {27'd0, count}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_count", {27'd0, count}, 32'd0);
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    check("t6_rst_aempty", {31'd0, almost_empty}, 32'd1);
    check("t6_rst_full", {31'd0, full}, 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    check("t6_post_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
